// File: rtl/secure_wb_pkg.sv
// rtl/secure_wb_pkg.sv - shared types and default constants for the secure writeback stage
package secure_wb_pkg;

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        UNLOCKED = 2'd1,
        LOCKOUT  = 2'd2
    } lock_state_e;

    localparam logic [9:0] DEF_PROT_BASE      = 10'h3C0;
    localparam int         DEF_UNLOCK_CYCLES  = 64;
    localparam int         DEF_LOCKOUT_CYCLES = 256;
    localparam int         DEF_MAX_BAD        = 3;

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_MEM = 1'b1;

endpackage

// File: rtl/wb_lock_fsm.sv
// rtl/wb_lock_fsm.sv - key-gated lock state machine with unlock window and lockout timers
module wb_lock_fsm
    import secure_wb_pkg::*;
#(
    parameter int KEY_W          = 16,
    parameter int UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int MAX_BAD        = DEF_MAX_BAD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             unlock_req,
    input  logic [KEY_W-1:0] unlock_key,
    input  logic             lock_req,
    input  logic [KEY_W-1:0] key_access,
    output logic             locked
);

    // One timer serves both the unlock window and the lockout period.
    localparam int TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX);
    localparam int BAD_W   = $clog2(MAX_BAD + 1);

    localparam logic [TMR_W-1:0] UNLOCK_LOAD  = TMR_W'(UNLOCK_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [BAD_W-1:0] BAD_LIMIT    = BAD_W'(MAX_BAD);

    lock_state_e      state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [BAD_W-1:0] bad_q,   bad_d;
    logic             key_ok;
    logic [BAD_W-1:0] bad_inc;

    assign key_ok  = (unlock_key == key_access);
    assign bad_inc = bad_q + BAD_W'(1);
    assign locked  = (state_q != UNLOCKED);

    // Next-state: relock has top priority, then per-state key handling and timer countdown.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        bad_d   = bad_q;
        if (lock_req) begin
            state_d = LOCKED;
            timer_d = '0;
        end else begin
            case (state_q)
                LOCKED: begin
                    if (unlock_req) begin
                        if (key_ok) begin
                            state_d = UNLOCKED;
                            timer_d = UNLOCK_LOAD;
                            bad_d   = '0;
                        end else if (bad_inc == BAD_LIMIT) begin
                            state_d = LOCKOUT;
                            timer_d = LOCKOUT_LOAD;
                            bad_d   = '0;
                        end else begin
                            bad_d   = bad_inc;
                        end
                    end
                end
                UNLOCKED: begin
                    if (unlock_req && key_ok) begin
                        timer_d = UNLOCK_LOAD;
                    end else if (unlock_req) begin
                        state_d = LOCKED;
                        timer_d = '0;
                        bad_d   = BAD_W'(1);
                    end else if (timer_q == '0) begin
                        state_d = LOCKED;
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
                LOCKOUT: begin
                    if (timer_q == '0) begin
                        state_d = LOCKED;
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
                default: begin
                    state_d = LOCKED;
                    timer_d = '0;
                    bad_d   = '0;
                end
            endcase
        end
    end

    // State, timer and wrong-key count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOCKED;
            timer_q <= '0;
            bad_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bad_q   <= bad_d;
        end
    end

endmodule

// File: rtl/secure_writeback.sv
// rtl/secure_writeback.sv - round-robin writeback port with protected window; audit outputs under SECURE_WB_AUDIT_EN
module secure_writeback
    import secure_wb_pkg::*;
#(
    parameter int                ADDR_W         = 10,
    parameter int                DATA_W         = 32,
    parameter int                KEY_W          = 16,
    parameter logic [ADDR_W-1:0] PROT_BASE      = ADDR_W'(DEF_PROT_BASE),
    parameter int                UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
    parameter int                MAX_BAD        = DEF_MAX_BAD,
    parameter int                LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int                VCNT_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              unlock_req,
    input  logic [KEY_W-1:0]  unlock_key,
    input  logic              lock_req,
    input  logic [KEY_W-1:0]  key_access,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              locked,
    output logic              viol_pulse,
    output logic [VCNT_W-1:0] viol_count
`ifdef SECURE_WB_AUDIT_EN
    ,
    output logic [ADDR_W-1:0] viol_addr,
    output logic              viol_src
`endif
);

    logic              rr_q, rr_d;
    logic              grant_alu, grant_mem, accept, drop;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    logic              wb_valid_q,   wb_valid_d;
    logic [ADDR_W-1:0] wb_addr_q,    wb_addr_d;
    logic [DATA_W-1:0] wb_data_q,    wb_data_d;
    logic              viol_pulse_q, viol_pulse_d;
    logic [VCNT_W-1:0] viol_count_q, viol_count_d;

    wb_lock_fsm #(
        .KEY_W          (KEY_W),
        .UNLOCK_CYCLES  (UNLOCK_CYCLES),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
        .MAX_BAD        (MAX_BAD)
    ) u_lock_fsm (
        .clk        (clk),
        .rst        (rst),
        .unlock_req (unlock_req),
        .unlock_key (unlock_key),
        .lock_req   (lock_req),
        .key_access (key_access),
        .locked     (locked)
    );

    // Arbitration: a lone requester always wins; on contention rr picks, then flips to the loser.
    always_comb begin
        grant_alu = alu_valid && (!mem_valid || (rr_q == SRC_ALU));
        grant_mem = mem_valid && (!alu_valid || (rr_q == SRC_MEM));
        rr_d      = rr_q;
        if (alu_valid && mem_valid) begin
            rr_d = grant_alu ? SRC_MEM : SRC_ALU;
        end
        sel_addr  = grant_mem ? mem_addr : alu_addr;
        sel_data  = grant_mem ? mem_data : alu_data;
        accept    = grant_alu || grant_mem;
        drop      = accept && locked && (sel_addr >= PROT_BASE);
    end

    assign alu_ready = grant_alu;
    assign mem_ready = grant_mem;

    // Write port and violation bookkeeping; dropped writes still complete the handshake.
    always_comb begin
        wb_valid_d   = accept && !drop;
        wb_addr_d    = wb_addr_q;
        wb_data_d    = wb_data_q;
        viol_pulse_d = drop;
        viol_count_d = viol_count_q;
        if (wb_valid_d) begin
            wb_addr_d = sel_addr;
            wb_data_d = sel_data;
        end
        if (drop && (viol_count_q != '1)) begin
            viol_count_d = viol_count_q + VCNT_W'(1);
        end
    end

    // Arbiter pointer and registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q         <= SRC_ALU;
            wb_valid_q   <= 1'b0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
            viol_pulse_q <= 1'b0;
            viol_count_q <= '0;
        end else begin
            rr_q         <= rr_d;
            wb_valid_q   <= wb_valid_d;
            wb_addr_q    <= wb_addr_d;
            wb_data_q    <= wb_data_d;
            viol_pulse_q <= viol_pulse_d;
            viol_count_q <= viol_count_d;
        end
    end

    assign wb_valid   = wb_valid_q;
    assign wb_addr    = wb_addr_q;
    assign wb_data    = wb_data_q;
    assign viol_pulse = viol_pulse_q;
    assign viol_count = viol_count_q;

`ifdef SECURE_WB_AUDIT_EN
    logic [ADDR_W-1:0] viol_addr_q, viol_addr_d;
    logic              viol_src_q,  viol_src_d;

    // Capture the origin of the most recent dropped write.
    always_comb begin
        viol_addr_d = viol_addr_q;
        viol_src_d  = viol_src_q;
        if (drop) begin
            viol_addr_d = sel_addr;
            viol_src_d  = grant_mem ? SRC_MEM : SRC_ALU;
        end
    end

    // Audit registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            viol_addr_q <= '0;
            viol_src_q  <= 1'b0;
        end else begin
            viol_addr_q <= viol_addr_d;
            viol_src_q  <= viol_src_d;
        end
    end

    assign viol_addr = viol_addr_q;
    assign viol_src  = viol_src_q;
`endif

endmodule

// File: tb/tb_secure_writeback.sv
// tb/tb_secure_writeback.sv - vector table, directed lock sequences and randomized model check
module tb_secure_writeback;

    localparam logic [15:0] KEY = 16'h0032;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, mem_valid, alu_ready, mem_ready;
    logic [9:0]  alu_addr, mem_addr;
    logic [31:0] alu_data, mem_data;
    logic        unlock_req, lock_req;
    logic [15:0] unlock_key, key_access;
    logic        wb_valid, locked, viol_pulse;
    logic [9:0]  wb_addr;
    logic [31:0] wb_data;
    logic [7:0]  viol_count;
`ifdef SECURE_WB_AUDIT_EN
    logic [9:0]  viol_addr;
    logic        viol_src;
`endif

    secure_writeback dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .unlock_req (unlock_req),
        .unlock_key (unlock_key),
        .lock_req   (lock_req),
        .key_access (key_access),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .locked     (locked),
        .viol_pulse (viol_pulse),
        .viol_count (viol_count)
`ifdef SECURE_WB_AUDIT_EN
        ,
        .viol_addr  (viol_addr),
        .viol_src   (viol_src)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        alu_valid  = 1'b0;
        mem_valid  = 1'b0;
        unlock_req = 1'b0;
        lock_req   = 1'b0;
        unlock_key = 16'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic unlock_cycle(input logic [15:0] k);
        unlock_req = 1'b1;
        unlock_key = k;
        tick();
        unlock_req = 1'b0;
    endtask

    function automatic logic [9:0] pick_addr();
        if ($urandom_range(0, 2) == 0) return 10'h3C0 + 10'($urandom_range(0, 63));
        return 10'($urandom_range(0, 1023));
    endfunction

    typedef struct {
        logic        av; logic [9:0] aa; logic [31:0] ad;
        logic        mv; logic [9:0] ma; logic [31:0] md;
        logic        ear; logic emr; logic ewv; logic [9:0] ewa; logic [31:0] ewd;
        logic        evp; logic [7:0] evc;
    } vec_t;

    vec_t vecs[13];

    // Behavioural model state for the randomized phase (absolute-cycle deadlines).
    int          m_cyc, m_unl, m_lo, m_bad, m_vc, md;
    bit          m_pref, m_wv, m_vp, ear, emr, a_pend, b_pend, key_ok;
    logic [9:0]  m_wa, m_va, sa;
    logic [31:0] m_wd, sd;

    initial begin
        key_access = KEY;
        alu_addr = '0; alu_data = '0; mem_addr = '0; mem_data = '0;
        idle();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_locked", locked, 1);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_addr", wb_addr, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_viol_pulse", viol_pulse, 0);
        chk("rst_viol_count", viol_count, 0);
`ifdef SECURE_WB_AUDIT_EN
        chk("rst_viol_addr", viol_addr, 0);
`endif
        rst = 1'b0;

        // Vector table: arbitration, hold behaviour and protected drops while locked.
        vecs[0]  = '{1'b1, 10'h005, 32'hDEADBEEF, 1'b0, 10'h000, 32'h0,        1'b1, 1'b0, 1'b1, 10'h005, 32'hDEADBEEF, 1'b0, 8'd0};
        vecs[1]  = '{1'b1, 10'h001, 32'hA0000001, 1'b1, 10'h002, 32'hB0000002, 1'b1, 1'b0, 1'b1, 10'h001, 32'hA0000001, 1'b0, 8'd0};
        vecs[2]  = '{1'b1, 10'h001, 32'hA0000001, 1'b1, 10'h002, 32'hB0000002, 1'b0, 1'b1, 1'b1, 10'h002, 32'hB0000002, 1'b0, 8'd0};
        vecs[3]  = '{1'b1, 10'h001, 32'hA0000001, 1'b1, 10'h002, 32'hB0000002, 1'b1, 1'b0, 1'b1, 10'h001, 32'hA0000001, 1'b0, 8'd0};
        vecs[4]  = '{1'b1, 10'h001, 32'hA0000001, 1'b1, 10'h002, 32'hB0000002, 1'b0, 1'b1, 1'b1, 10'h002, 32'hB0000002, 1'b0, 8'd0};
        vecs[5]  = '{1'b0, 10'h001, 32'hA0000001, 1'b0, 10'h002, 32'hB0000002, 1'b0, 1'b0, 1'b0, 10'h002, 32'hB0000002, 1'b0, 8'd0};
        vecs[6]  = '{1'b0, 10'h000, 32'h0,        1'b1, 10'h010, 32'hB0000010, 1'b0, 1'b1, 1'b1, 10'h010, 32'hB0000010, 1'b0, 8'd0};
        vecs[7]  = '{1'b1, 10'h011, 32'hA0000011, 1'b1, 10'h012, 32'hB0000012, 1'b1, 1'b0, 1'b1, 10'h011, 32'hA0000011, 1'b0, 8'd0};
        vecs[8]  = '{1'b0, 10'h000, 32'h0,        1'b1, 10'h012, 32'hB0000012, 1'b0, 1'b1, 1'b1, 10'h012, 32'hB0000012, 1'b0, 8'd0};
        vecs[9]  = '{1'b1, 10'h3C4, 32'hA00003C4, 1'b1, 10'h015, 32'hB0000015, 1'b0, 1'b1, 1'b1, 10'h015, 32'hB0000015, 1'b0, 8'd0};
        vecs[10] = '{1'b1, 10'h3C4, 32'hA00003C4, 1'b0, 10'h000, 32'h0,        1'b1, 1'b0, 1'b0, 10'h015, 32'hB0000015, 1'b1, 8'd1};
        vecs[11] = '{1'b0, 10'h000, 32'h0,        1'b1, 10'h3C0, 32'hB00003C0, 1'b0, 1'b1, 1'b0, 10'h015, 32'hB0000015, 1'b1, 8'd2};
        vecs[12] = '{1'b0, 10'h000, 32'h0,        1'b1, 10'h3BF, 32'hB00003BF, 1'b0, 1'b1, 1'b1, 10'h3BF, 32'hB00003BF, 1'b0, 8'd2};

        for (int i = 0; i < 13; i++) begin
            alu_valid = vecs[i].av; alu_addr = vecs[i].aa; alu_data = vecs[i].ad;
            mem_valid = vecs[i].mv; mem_addr = vecs[i].ma; mem_data = vecs[i].md;
            #1;
            chk($sformatf("vec%0d_alu_ready", i), alu_ready, vecs[i].ear);
            chk($sformatf("vec%0d_mem_ready", i), mem_ready, vecs[i].emr);
            tick();
            chk($sformatf("vec%0d_wb_valid", i), wb_valid, vecs[i].ewv);
            chk($sformatf("vec%0d_wb_addr", i), wb_addr, vecs[i].ewa);
            chk($sformatf("vec%0d_wb_data", i), wb_data, vecs[i].ewd);
            chk($sformatf("vec%0d_viol_pulse", i), viol_pulse, vecs[i].evp);
            chk($sformatf("vec%0d_viol_count", i), viol_count, vecs[i].evc);
`ifdef SECURE_WB_AUDIT_EN
            if (vecs[i].evp) begin
                chk($sformatf("vec%0d_viol_addr", i), viol_addr, vecs[i].ear ? vecs[i].aa : vecs[i].ma);
                chk($sformatf("vec%0d_viol_src", i), viol_src, vecs[i].emr);
            end
`endif
        end
        idle();

        // Unlock window: protected write lands, window ends after 64 cycles.
        do_reset();
        unlock_cycle(KEY);
        chk("unlock_opens", locked, 0);
        alu_valid = 1'b1; alu_addr = 10'h3FF; alu_data = 32'h12345678;
        tick();
        alu_valid = 1'b0;
        chk("prot_write_lands", wb_valid, 1);
        chk("prot_write_addr", wb_addr, 10'h3FF);
        repeat (62) tick();
        chk("window_last_cycle", locked, 0);
        tick();
        chk("window_expired", locked, 1);
        alu_valid = 1'b1;
        tick();
        alu_valid = 1'b0;
        chk("expired_write_dropped", wb_valid, 0);
        chk("expired_viol_pulse", viol_pulse, 1);
        chk("expired_viol_count", viol_count, 1);

        // Unlock in the same cycle as a protected write does not authorise it; reset relocks.
        do_reset();
        unlock_req = 1'b1; unlock_key = KEY;
        alu_valid = 1'b1; alu_addr = 10'h3D0;
        tick();
        idle();
        chk("same_cycle_unlock_drop", wb_valid, 0);
        chk("same_cycle_unlock_pulse", viol_pulse, 1);
        chk("same_cycle_unlock_open", locked, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("reset_mid_window_locked", locked, 1);
        chk("reset_mid_window_count", viol_count, 0);

        // Lockout after three wrong keys; correct keys ignored until it expires.
        do_reset();
        repeat (3) unlock_cycle(16'h0000);
        chk("lockout_locked", locked, 1);
        repeat (9) tick();
        unlock_cycle(KEY);
        chk("lockout_ignores_key", locked, 1);
        repeat (245) tick();
        unlock_cycle(KEY);
        chk("lockout_last_cycle_ignores", locked, 1);
        unlock_cycle(KEY);
        chk("after_lockout_unlocks", locked, 0);

        // Wrong key while unlocked leaves bad=1, so two more wrong keys reach lockout.
        do_reset();
        unlock_cycle(KEY);
        unlock_cycle(16'h1111);
        chk("wrong_key_relocks", locked, 1);
        unlock_cycle(16'h1111);
        unlock_cycle(16'h1111);
        unlock_cycle(KEY);
        chk("bad_carried_to_lockout", locked, 1);

        // lock_req beats a simultaneous correct unlock.
        do_reset();
        unlock_cycle(KEY);
        lock_req = 1'b1; unlock_req = 1'b1; unlock_key = KEY;
        tick();
        idle();
        chk("lock_beats_unlock", locked, 1);

        // Violation counter saturates at all-ones.
        do_reset();
        alu_valid = 1'b1; alu_addr = 10'h3C5; alu_data = 32'h0;
        repeat (255) tick();
        chk("viol_count_reaches_max", viol_count, 8'hFF);
        tick();
        chk("viol_count_saturated", viol_count, 8'hFF);
        chk("viol_pulse_at_saturation", viol_pulse, 1);
        idle();

        // Randomized traffic against a deadline-based model.
        do_reset();
        m_cyc = 0; m_unl = 0; m_lo = 0; m_bad = 0; m_vc = 0; m_pref = 1'b0;
        m_wa = '0; m_wd = '0; m_va = '0; a_pend = 1'b0; b_pend = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!a_pend) begin
                alu_valid = 1'($urandom_range(0, 1)); alu_addr = pick_addr(); alu_data = $urandom;
            end
            if (!b_pend) begin
                mem_valid = 1'($urandom_range(0, 1)); mem_addr = pick_addr(); mem_data = $urandom;
            end
            unlock_req = ($urandom_range(0, 11) == 0);
            unlock_key = ($urandom_range(0, 2) != 0) ? KEY : 16'($urandom);
            lock_req   = ($urandom_range(0, 79) == 0);
            #1;
            md  = (m_lo > m_cyc) ? 2 : ((m_unl > m_cyc) ? 1 : 0);
            ear = alu_valid && (!mem_valid || !m_pref);
            emr = mem_valid && (!alu_valid || m_pref);
            chk("rnd_alu_ready", alu_ready, ear);
            chk("rnd_mem_ready", mem_ready, emr);
            chk("rnd_locked", locked, md != 1);
            m_wv = 1'b0; m_vp = 1'b0;
            if (ear || emr) begin
                sa = ear ? alu_addr : mem_addr;
                sd = ear ? alu_data : mem_data;
                if (md != 1 && sa >= 10'h3C0) begin
                    m_vp = 1'b1; m_va = sa;
                    if (m_vc < 255) m_vc++;
                end else begin
                    m_wv = 1'b1; m_wa = sa; m_wd = sd;
                end
            end
            if (alu_valid && mem_valid) m_pref = !m_pref;
            key_ok = (unlock_key == key_access);
            if (lock_req) begin
                m_unl = 0; m_lo = 0;
            end else if (unlock_req && md == 0) begin
                if (key_ok) begin
                    m_unl = m_cyc + 65; m_bad = 0;
                end else begin
                    m_bad++;
                    if (m_bad == 3) begin
                        m_lo = m_cyc + 257; m_bad = 0;
                    end
                end
            end else if (unlock_req && md == 1) begin
                if (key_ok) m_unl = m_cyc + 65;
                else begin
                    m_unl = 0; m_bad = 1;
                end
            end
            a_pend = alu_valid && !ear;
            b_pend = mem_valid && !emr;
            tick();
            m_cyc++;
            chk("rnd_wb_valid", wb_valid, m_wv);
            chk("rnd_wb_addr", wb_addr, m_wa);
            chk("rnd_wb_data", wb_data, m_wd);
            chk("rnd_viol_pulse", viol_pulse, m_vp);
            chk("rnd_viol_count", viol_count, m_vc);
`ifdef SECURE_WB_AUDIT_EN
            chk("rnd_viol_addr", viol_addr, m_va);
`endif
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/secure_writeback.md
Name: secure_writeback

Overview:
- Writeback stage directly upstream of the register/memory array.
- Accepts ALU-result and load-result write requests through valid/ready handshakes and arbitrates them round-robin onto one registered write port.
- Enforces key-gated protection of a high address window, using a lock state machine and the array's key_access constant.
- Drops and counts illegal writes.

Parameters:
- ADDR_W, 10, address width; matches the 1024-entry array.
- DATA_W, 32, write data width.
- KEY_W, 16, unlock key width.
- PROT_BASE, 10'h3C0, lowest protected address; protected window is PROT_BASE..2^ADDR_W-1.
- UNLOCK_CYCLES, 64, unlock window length in cycles.
- MAX_BAD, 3, consecutive wrong keys before lockout.
- LOCKOUT_CYCLES, 256, lockout duration in cycles.
- VCNT_W, 8, violation counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- alu_valid  in  1  ALU write request
- alu_ready  out  1  ALU request accepted this cycle
- alu_addr  in  ADDR_W  ALU destination address
- alu_data  in  DATA_W  ALU result
- mem_valid  in  1  load write request
- mem_ready  out  1  load request accepted this cycle
- mem_addr  in  ADDR_W  load destination address
- mem_data  in  DATA_W  load data
- unlock_req  in  1  unlock attempt strobe
- unlock_key  in  KEY_W  key presented with unlock_req
- lock_req  in  1  immediate relock strobe
- key_access  in  KEY_W  reference key from the register/memory array
- wb_valid  out  1  write strobe to the array
- wb_addr  out  ADDR_W  write address
- wb_data  out  DATA_W  write data
- locked  out  1  1 when in the LOCKED or LOCKOUT state
- viol_pulse  out  1  one-cycle pulse per dropped write
- viol_count  out  VCNT_W  saturating count of dropped writes

Behaviour:
- Reset: all outputs 0 except locked=1.
  - State=LOCKED, rr pointer=0 (ALU preferred), timers=0, bad count=0.
  - Reset mid-window or mid-lockout returns to LOCKED immediately.
- Handshake: a transfer occurs when valid&&ready.
  - ready is combinational from both valids and rr: a sole valid source is ready.
  - When both are valid, the rr-preferred source is ready and the other is not.
  - After a contested grant, rr points to the loser.
  - Uncontested grants leave rr unchanged.
  - Requesters hold addr/data stable until accepted.
- Latency: accepted request appears on wb_* the next cycle.
  - wb_valid is high for exactly 1 cycle per accepted legal request.
  - wb_addr/wb_data hold their last values when wb_valid=0.
- Protection check uses the registered state at acceptance time:
  - addr>=PROT_BASE while locked: request is still accepted (ready=1) but dropped.
  - On a drop, wb_valid=0 next cycle, viol_pulse=1 next cycle, and viol_count increments, saturating at all-ones.
- An unlock in the same cycle as a protected write does not authorise that write.
- FSM states: LOCKED, UNLOCKED, LOCKOUT.
  - LOCKED:
    - unlock_req with unlock_key==key_access -> UNLOCKED; timer=UNLOCK_CYCLES-1; bad=0.
    - Wrong key -> bad+1; when bad reaches MAX_BAD -> LOCKOUT, timer=LOCKOUT_CYCLES-1, bad=0.
  - UNLOCKED:
    - Timer decrements each cycle; at 0 -> LOCKED.
    - Correct unlock_req reloads the timer.
    - Wrong key -> LOCKED with bad=1.
  - LOCKOUT:
    - unlock_req is ignored and does not change bad.
    - Timer decrements; at 0 -> LOCKED.
  - lock_req in any state -> LOCKED, bad unchanged; lock_req beats a simultaneous unlock_req.
- Unprotected addresses (<PROT_BASE) are written in every state.

Optional Feature:
- Macro: SECURE_WB_AUDIT_EN.
- When defined:
  - Adds output viol_addr (ADDR_W), reset 0.
  - viol_addr latches the address of the most recent dropped write, updating in the same cycle as viol_pulse.
  - Adds output viol_src (1), where 0=ALU and 1=MEM.
- When undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package secure_wb_pkg holds:
  - state enum (LOCKED, UNLOCKED, LOCKOUT);
  - default PROT_BASE, UNLOCK_CYCLES, LOCKOUT_CYCLES, MAX_BAD constants;
  - source encoding (SRC_ALU=0, SRC_MEM=1).
- One sub-module: wb_lock_fsm, containing the state, timers and bad counter.
  - Inputs: unlock_req, unlock_key, lock_req, key_access.
  - Output: locked.
  - Arbitration and the datapath stay in the top module.

Test Plan:
- Reset, then alu_valid=1, addr=10'h005, data=32'hDEADBEEF:
  - alu_ready=1 in the same cycle;
  - next cycle wb_valid=1, wb_addr=10'h005, wb_data=32'hDEADBEEF.
- Both valid for 4 cycles (ALU addr 1, MEM addr 2):
  - grants alternate ALU, MEM, ALU, MEM;
  - wb_addr sequence is 1, 2, 1, 2, one per cycle.
- Locked, ALU write to 10'h3C4:
  - wb_valid=0, viol_pulse=1, viol_count=1;
  - with SECURE_WB_AUDIT_EN, viol_addr=10'h3C4 and viol_src=0.
- unlock_key=16'h0032 with key_access=16'h0032, then write 10'h3FF at cycle+1:
  - the write lands;
  - 64 cycles after the unlock, locked=1 and the same write is dropped.
- Three unlock_req with key 16'h0000:
  - LOCKOUT;
  - a correct key at cycle+10 is ignored (locked=1);
  - after 256 cycles a correct key unlocks.
- UNLOCKED with lock_req and a correct unlock_req in the same cycle: locked=1 the next cycle.
